// File: rtl/command_issue_scheduler_if.sv
// Request, issue and response signal bundle for the command issue scheduler.
// The master modport is the scheduler; the slave modport is its surrounding logic.
interface command_issue_scheduler_if #(
    parameter int NUM_REQ  = 3,
    parameter int REQ_ID_W = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*13-1:0] req_command;
    logic [NUM_REQ*64-1:0] req_address;
    logic [NUM_REQ*12-1:0] req_size;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  cmd_valid;
    logic [12:0]           cmd_command;
    logic [63:0]           cmd_address;
    logic [11:0]           cmd_size;
    logic [7:0]            cmd_tag;
    logic [REQ_ID_W-1:0]   cmd_req_id;

    logic                  rsp_valid;
    logic [7:0]            rsp_tag;

    modport master (
        input  req_valid, req_command, req_address, req_size, rsp_valid, rsp_tag,
        output req_ready, cmd_valid, cmd_command, cmd_address, cmd_size, cmd_tag, cmd_req_id
    );

    modport slave (
        output req_valid, req_command, req_address, req_size, rsp_valid, rsp_tag,
        input  req_ready, cmd_valid, cmd_command, cmd_address, cmd_size, cmd_tag, cmd_req_id
    );
endinterface

// File: rtl/command_issue_scheduler.sv
// Round-robin sharing of the PSL command interface among NUM_REQ requesters,
// with command-credit (croom) accounting and a tag pool recycled on responses.
module command_issue_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_TAGS = 64,
    parameter int REQ_ID_W = 3
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       enabled_in,
    input  logic [7:0]                 room_in,
    command_issue_scheduler_if.master  bus,
    output logic [8:0]                 outstanding,
    output logic [8:0]                 credits,
    output logic                       idle,
    output logic                       err_tag
);
    localparam int TAG_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    logic                  r_enabled_q;
    logic [NUM_TAGS-1:0]   r_busy;
    logic [8:0]            r_credits;
    logic [8:0]            r_outstanding;
    logic [REQ_ID_W-1:0]   r_rr;
    logic                  r_err_tag;
    logic                  r_cmd_valid;
    logic [12:0]           r_cmd_command;
    logic [63:0]           r_cmd_address;
    logic [11:0]           r_cmd_size;
    logic [7:0]            r_cmd_tag;
    logic [REQ_ID_W-1:0]   r_cmd_req_id;

    logic                  w_tag_free;
    logic [TAG_W-1:0]      w_alloc_idx;
    logic [2*NUM_REQ-1:0]  w_dbl_req;
    logic                  w_win_found;
    logic [REQ_ID_W-1:0]   w_win_id;
    logic [REQ_ID_W-1:0]   w_next_rr;
    logic                  w_grant;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic [12:0]           w_sel_command;
    logic [63:0]           w_sel_address;
    logic [11:0]           w_sel_size;
    logic [TAG_W-1:0]      w_rsp_idx;
    logic                  w_rsp_in_range;
    logic                  w_rsp_ok;
    logic                  w_rsp_err;
    logic                  w_load;
    logic [NUM_TAGS-1:0]   w_busy_next;

    // Lowest-index free tag, scanning from the top so the lowest hit is kept last.
    always_comb begin
        w_tag_free  = ~(&r_busy);
        w_alloc_idx = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            w_alloc_idx = (!r_busy[t]) ? TAG_W'(t) : w_alloc_idx;
        end
    end

    // Round-robin winner: rotate the request vector so the rr pointer sits at bit 0.
    always_comb begin
        w_dbl_req   = {bus.req_valid, bus.req_valid} >> r_rr;
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int sum;
            sum         = int'(r_rr) + k;
            sum         = (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
            w_win_id    = (w_dbl_req[k] && !w_win_found) ? REQ_ID_W'(sum) : w_win_id;
            w_win_found = w_win_found | w_dbl_req[k];
        end
        w_next_rr = (int'(w_win_id) == NUM_REQ - 1) ? '0 : w_win_id + REQ_ID_W'(1);
    end

    // Grant qualification and the one-hot handshake back to the winner.
    always_comb begin
        w_grant = !rst && enabled_in && r_enabled_q && (r_credits != 9'd0)
                  && w_tag_free && w_win_found;
        if (w_grant) begin
            w_req_ready = NUM_REQ'(1) << w_win_id;
        end else begin
            w_req_ready = '0;
        end
    end

    // Payload mux for the winning requester.
    always_comb begin
        w_sel_command = 13'd0;
        w_sel_address = 64'd0;
        w_sel_size    = 12'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_command = (w_win_id == REQ_ID_W'(i)) ? bus.req_command[13*i +: 13] : w_sel_command;
            w_sel_address = (w_win_id == REQ_ID_W'(i)) ? bus.req_address[64*i +: 64] : w_sel_address;
            w_sel_size    = (w_win_id == REQ_ID_W'(i)) ? bus.req_size[12*i +: 12]    : w_sel_size;
        end
    end

    // Response qualification; a busy tag can never equal the tag being allocated.
    always_comb begin
        w_rsp_idx      = bus.rsp_tag[TAG_W-1:0];
        w_rsp_in_range = ({1'b0, bus.rsp_tag} < 9'(NUM_TAGS));
        w_rsp_ok       = bus.rsp_valid && w_rsp_in_range && r_busy[w_rsp_idx];
        w_rsp_err      = bus.rsp_valid && !w_rsp_ok;
        w_load         = enabled_in && !r_enabled_q;
        w_busy_next    = r_busy;
        if (w_grant) begin
            w_busy_next[w_alloc_idx] = 1'b1;
        end else begin
            w_busy_next = r_busy;
        end
        if (w_rsp_ok) begin
            w_busy_next[w_rsp_idx] = 1'b0;
        end else begin
            w_busy_next = w_busy_next;
        end
    end

    // All scheduler state: enable history, tag pool, counters, rr pointer, issue register.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_enabled_q   <= 1'b0;
            r_busy        <= '0;
            r_credits     <= 9'd0;
            r_outstanding <= 9'd0;
            r_rr          <= '0;
            r_err_tag     <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_command <= 13'd0;
            r_cmd_address <= 64'd0;
            r_cmd_size    <= 12'd0;
            r_cmd_tag     <= 8'd0;
            r_cmd_req_id  <= '0;
        end else begin
            r_enabled_q <= enabled_in;
            r_busy      <= w_busy_next;
            r_cmd_valid <= w_grant;
            if (w_grant) begin
                r_cmd_command <= w_sel_command;
                r_cmd_address <= w_sel_address;
                r_cmd_size    <= w_sel_size;
                r_cmd_tag     <= 8'(w_alloc_idx);
                r_cmd_req_id  <= w_win_id;
                r_rr          <= w_next_rr;
            end
            case ({w_grant, w_rsp_ok})
                2'b10:   r_outstanding <= r_outstanding + 9'd1;
                2'b01:   r_outstanding <= r_outstanding - 9'd1;
                default: r_outstanding <= r_outstanding;
            endcase
            // Enable rising edge overwrites the credit count with the PSL room.
            if (w_load) begin
                r_credits <= {1'b0, room_in};
            end else begin
                case ({w_grant, w_rsp_ok})
                    2'b10:   r_credits <= r_credits - 9'd1;
                    2'b01:   r_credits <= (r_credits == 9'd511) ? r_credits : r_credits + 9'd1;
                    default: r_credits <= r_credits;
                endcase
            end
            if (w_rsp_err) begin
                r_err_tag <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_command = r_cmd_command;
    assign bus.cmd_address = r_cmd_address;
    assign bus.cmd_size    = r_cmd_size;
    assign bus.cmd_tag     = r_cmd_tag;
    assign bus.cmd_req_id  = r_cmd_req_id;
    assign outstanding     = r_outstanding;
    assign credits         = r_credits;
    assign idle            = !r_enabled_q && (r_outstanding == 9'd0);
    assign err_tag         = r_err_tag;
endmodule

// File: doc/command_issue_scheduler.md
Name: command_issue_scheduler

Overview:
Shares the single PSL command interface between NUM_REQ requesters (read engine, write engine, WED/restart logic) using round-robin arbitration. Owns command-credit accounting (PSL croom) and the command tag pool. Each issued command gets a free tag; tags and credits are returned on PSL response. Sits between the per-engine command buffers and the command-driving/parity stage.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
NUM_TAGS, 64, size of tag pool; tags 0..NUM_TAGS-1 (power of two, max 256)
REQ_ID_W, 3, width of requester id field (clog2(NUM_REQ) rounded up, min 1)

Ports:
clock  in  1  clock
rst  in  1  synchronous reset, active-high
enabled_in  in  1  scheduler enable; rising edge loads credits
room_in  in  8  PSL command room; sampled only on enabled_in rising edge
req_valid  in  NUM_REQ  request pending, bit i = requester i
req_command  in  NUM_REQ*13  command code, slice i = [13*i +: 13]
req_address  in  NUM_REQ*64  effective address, slice i
req_size  in  NUM_REQ*12  transfer size, slice i
req_ready  out  NUM_REQ  one-hot grant; request consumed this cycle
cmd_valid  out  1  command issued to command-drive stage
cmd_command  out  13  issued command code
cmd_address  out  64  issued address
cmd_size  out  12  issued size
cmd_tag  out  8  allocated tag
cmd_req_id  out  REQ_ID_W  requester granted
rsp_valid  in  1  PSL response strobe
rsp_tag  in  8  tag being completed
outstanding  out  9  tags currently in flight
credits  out  9  current command credits
idle  out  1  not enabled and outstanding==0
err_tag  out  1  sticky: response for tag not in flight, or rsp_tag>=NUM_TAGS

Behaviour:
- Reset (rst=1 at clock edge): all tags free, credits=0, outstanding=0, rr pointer=0, err_tag=0, cmd_valid=0, cmd_command/address/size/tag/req_id=0, req_ready=0, idle=1, internal enabled_q=0.
- enabled_q registers enabled_in. On cycle where enabled_in=1 and enabled_q=0: credits <= room_in (zero-extended). No grant that cycle.
- Grant condition (cycle t, combinational): enabled_in & enabled_q & credits>0 & any free tag & |req_valid. Otherwise req_ready=0.
- Arbitration: round-robin; search starts at rr pointer, wraps at NUM_REQ-1 -> 0; first valid requester wins. On grant of i, rr <= (i+1) mod NUM_REQ. No grant -> rr unchanged.
- Tag allocation: lowest-index free tag from tag bitmap as it stands at start of cycle t.
- Latency: grant at t -> cmd_valid=1 at t+1 for exactly one cycle with granted fields, cmd_tag, cmd_req_id. Max one issue per cycle; back-to-back issues allowed. cmd_* data hold last value when cmd_valid=0.
- Granted tag marked busy at edge of t; credits -1, outstanding +1.
- Response: rsp_valid with busy tag -> tag freed, credits +1, outstanding -1 at that edge. Non-busy or out-of-range tag -> no state change, err_tag <= 1 (cleared only by rst).
- Simultaneous grant and valid response same cycle: credits and outstanding net unchanged; freed tag not allocatable until next cycle; if rsp_tag equals tag being allocated (impossible unless error) treat as error, allocation wins.
- Credits saturate at 511; never underflow (grant gated by credits>0).
- Pool full (outstanding==NUM_TAGS) or credits==0: requests stall, req_valid held by requester; no loss, no reordering per requester.
- enabled_in falls: grants stop next cycle evaluation (same cycle t uses enabled_in); outstanding responses still processed; idle=1 once outstanding==0. Re-enable reloads credits from room_in (overwrites).
- rst mid-operation: immediate return to reset state; in-flight tags forgotten.

Test Plan:
- Reset then enabled_in=1, room_in=4, req0 valid for 6 commands, no responses -> 4 issues, tags 0,1,2,3 at cmd_valid cycles t+1..; credits=0, stall; one rsp_tag=1 -> next issue gets tag 1, credits back to 0.
- All 3 requesters valid continuously, room=64, responses immediate -> grant order 0,1,2,0,1,2; cmd_req_id matches; one issue per cycle.
- NUM_TAGS=64, room_in=100, no responses -> exactly 64 issues, outstanding=64, credits=36, req_ready=0 thereafter.
- Same-cycle grant + rsp_valid for busy tag 5 at credits=1 -> credits stays 1, outstanding unchanged, new command not tagged 5 that cycle.
- rsp_valid with tag 9 never issued -> err_tag=1, credits/outstanding unchanged; persists until rst.
- Drop enabled_in with 3 outstanding -> no further cmd_valid; idle=1 cycle after third response; rst mid-stream -> all outputs reset values next cycle.
